// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the Lab2 UART receive path and its sample-tick
// generator: frame geometry, receiver FSM state encoding and the baud divisor
// table.
//
// Divisor table, DIVISOR[sel] = round(CLK_HZ / (16 * baud)). At 50 MHz:
//   sel : 0     1     2     3     4     5     6     7
//   baud: 300   1200  4800  9600  19200 38400 57600 115200
//   div : 10417 2604  651   326   163   81    54    27
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned DATA_BITS       = 8;
   localparam int unsigned SAMPLES_PER_BIT = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   localparam int unsigned BAUD_RATE [8] = '{
      300, 1200, 4800, 9600, 19200, 38400, 57600, 115200
   };

   // Clock cycles per sample tick, rounded to nearest. Only ever evaluated
   // as a constant function, so it never becomes a hardware divider.
   function automatic logic [15:0] baud_divisor(input int unsigned clk_hz,
                                                input logic [2:0]  sel);
      int unsigned baud;
      baud = BAUD_RATE[sel];
      return 16'((clk_hz + (SAMPLES_PER_BIT / 2) * baud) /
                 (SAMPLES_PER_BIT * baud));
   endfunction

   // XOR of all data bits; zero means an even number of ones.
   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Bundle between the UART receiver and the logic around it.
//   baud_select : line rate select (see uart_pkg divisor table)
//   Rx_EN       : receiver enable
//   RxD         : asynchronous serial line, idles high
//   Rx_DATA     : last completed frame's byte
//   Rx_VALID    : 1-cycle pulse, good frame
//   Rx_FERROR   : 1-cycle pulse, stop bit sampled low
//   Rx_PERROR   : 1-cycle pulse, parity mismatch
// slave  : the receiver itself
// master : the side that drives the line/controls and consumes the results
// -----------------------------------------------------------------------------
interface uart_rx_if;
   import uart_pkg::*;

   logic [2:0]           baud_select;
   logic                 Rx_EN;
   logic                 RxD;
   logic [DATA_BITS-1:0] Rx_DATA;
   logic                 Rx_VALID;
   logic                 Rx_FERROR;
   logic                 Rx_PERROR;

   modport slave (
      input  baud_select, Rx_EN, RxD,
      output Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR
   );

   modport master (
      output baud_select, Rx_EN, RxD,
      input  Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR
   );

endinterface

// File: rtl/uart_sample_tick.sv
// -----------------------------------------------------------------------------
// uart_sample_tick
// 16x-oversampling tick generator. A 16-bit counter counts clk cycles up to
// the selected divisor and emits a one-cycle sample tick on wrap. The
// transmitter can reuse it and divide the ticks by 16 for its bit clock.
//   clk           : system clock
//   reset         : synchronous, active-low
//   en_i          : count enable; counter held at 0 when low
//   baud_select_i : divisor select; any change restarts the count at 0
//   sample_tick_o : one-cycle pulse every DIVISOR[baud_select_i] cycles
// -----------------------------------------------------------------------------
module uart_sample_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en_i,
   input  logic [2:0] baud_select_i,
   output logic       sample_tick_o
);

   localparam logic [15:0] DIV_TAB [8] = '{
      baud_divisor(CLK_HZ, 3'd0), baud_divisor(CLK_HZ, 3'd1),
      baud_divisor(CLK_HZ, 3'd2), baud_divisor(CLK_HZ, 3'd3),
      baud_divisor(CLK_HZ, 3'd4), baud_divisor(CLK_HZ, 3'd5),
      baud_divisor(CLK_HZ, 3'd6), baud_divisor(CLK_HZ, 3'd7)
   };

   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  sel_q;
   logic [15:0] last_cnt;

   assign last_cnt = DIV_TAB[baud_select_i] - 16'd1;

   always_comb begin
      cnt_d         = cnt_q + 16'd1;
      sample_tick_o = 1'b0;
      // A freshly changed select must not fire on a count that belonged to
      // the old divisor, so it suppresses the tick as well as restarting.
      if (!en_i || (baud_select_i != sel_q)) begin
         cnt_d = '0;
      end else if (cnt_q == last_cnt) begin
         cnt_d         = '0;
         sample_tick_o = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      sel_q <= baud_select_i;
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start bit, 8 data bits LSB first, optional even parity,
// 1 stop bit, 16x oversampled with decisions at the middle sample of a bit.
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous, active-low
//   bus   : uart_rx_if.slave (baud_select, Rx_EN, RxD in;
//           Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR out)
// Parameters: CLK_HZ feeds the divisor table, OVERSAMPLE must be 16,
// PARITY_EN selects whether a parity bit is present and checked.
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned OVERSAMPLE = 16,
   parameter bit          PARITY_EN  = 1'b1
) (
   input  logic      clk,
   input  logic      reset,
   uart_rx_if.slave  bus
);

   localparam int unsigned    SC_W     = $clog2(OVERSAMPLE);
   localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
   localparam logic [2:0]     IDX_LAST = 3'(DATA_BITS - 1);

   logic                 sample_tick;
   logic [1:0]           sync_q;
   logic                 rxd_s;

   rx_state_e            state_q, state_d;
   logic [SC_W-1:0]      sc_q, sc_d;
   logic [2:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_out_q, perr_out_d;

   uart_sample_tick #(
      .CLK_HZ (CLK_HZ)
   ) u_tick (
      .clk           (clk),
      .reset         (reset),
      .en_i          (bus.Rx_EN),
      .baud_select_i (bus.baud_select),
      .sample_tick_o (sample_tick)
   );

   assign rxd_s = sync_q[1];

   always_comb begin
      state_d    = state_q;
      sc_d       = sc_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
      perr_out_d = 1'b0;

      if (!bus.Rx_EN) begin
         // Disabling abandons any frame in progress silently.
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!rxd_s) begin
                  state_d = ST_START;
                  sc_d    = '0;
               end
            end
            ST_START: begin
               if (sample_tick) begin
                  sc_d = sc_q + 1'b1;
                  if ((sc_q == SC_MID) && rxd_s) begin
                     state_d = ST_IDLE;        // start bit too short: glitch
                  end else if (sc_q == SC_LAST) begin
                     state_d = ST_DATA;
                     idx_d   = '0;
                  end
               end
            end
            ST_DATA: begin
               if (sample_tick) begin
                  sc_d = sc_q + 1'b1;
                  if (sc_q == SC_MID) begin
                     shift_d[idx_q] = rxd_s;
                  end
                  if (sc_q == SC_LAST) begin
                     if (idx_q == IDX_LAST) begin
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                     end else begin
                        idx_d = idx_q + 3'd1;
                     end
                  end
               end
            end
            ST_PARITY: begin
               if (sample_tick) begin
                  sc_d = sc_q + 1'b1;
                  if (sc_q == SC_MID) begin
                     perr_d = parity_of(shift_q) ^ rxd_s;
                  end
                  if (sc_q == SC_LAST) begin
                     state_d = ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               if (sample_tick) begin
                  sc_d = sc_q + 1'b1;
                  // Leave at mid-stop rather than end of bit so the next
                  // start edge is caught even if the sender runs a little fast.
                  if (sc_q == SC_MID) begin
                     state_d    = ST_IDLE;
                     data_d     = shift_q;
                     ferr_d     = ~rxd_s;
                     perr_out_d = PARITY_EN && perr_q;
                     valid_d    = rxd_s && !(PARITY_EN && perr_q);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q     <= 2'b11;
         state_q    <= ST_IDLE;
         sc_q       <= '0;
         idx_q      <= '0;
         perr_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         perr_out_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], bus.RxD};
         state_q    <= state_d;
         sc_q       <= sc_d;
         idx_q      <= idx_d;
         perr_q     <= perr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         perr_out_q <= perr_out_d;
      end
   end

   // Assembly register is only observed after being fully rewritten by a
   // frame, so it carries no reset.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   assign bus.Rx_DATA   = data_q;
   assign bus.Rx_VALID  = valid_q;
   assign bus.Rx_FERROR = ferr_q;
   assign bus.Rx_PERROR = perr_out_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Two receivers: dut_a at 50 MHz / 115200 with parity, dut_b at 5 MHz with
// baud_select=9600 and no parity (divisor 33, 528 clk per bit), the latter
// used for back-to-back frames.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int BIT_A = 27 * 16;
   localparam int BIT_B = 33 * 16;
   // A low stop bit is held only 3/4 of a bit: the receiver samples it at
   // mid-bit, and the shortened tail is then rejected as a start glitch
   // instead of straddling the next frame's start bit.
   localparam int STOP_LOW_A = (BIT_A * 3) / 4;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_v;
      logic       exp_fe;
      logic       exp_pe;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   uart_rx_if bus_a ();
   uart_rx_if bus_b ();

   uart_rx #(
      .CLK_HZ     (50000000),
      .OVERSAMPLE (16),
      .PARITY_EN  (1'b1)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   uart_rx #(
      .CLK_HZ     (5000000),
      .OVERSAMPLE (16),
      .PARITY_EN  (1'b0)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   int n_vec  = 0;
   int n_miss = 0;

   int n_val_a = 0;
   int n_fe_a  = 0;
   int n_pe_a  = 0;
   int n_err_b = 0;
   logic [7:0] rx_b [$];

   // Pulse counters, sampled on the falling edge. A pulse longer than one
   // cycle shows up as an extra count.
   always @(negedge clk) begin
      if (bus_a.Rx_VALID === 1'b1)  n_val_a++;
      if (bus_a.Rx_FERROR === 1'b1) n_fe_a++;
      if (bus_a.Rx_PERROR === 1'b1) n_pe_a++;
      if (bus_b.Rx_VALID === 1'b1)  rx_b.push_back(bus_b.Rx_DATA);
      if ((bus_b.Rx_FERROR === 1'b1) || (bus_b.Rx_PERROR === 1'b1)) n_err_b++;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input bit to_b, input logic v, input int len);
      if (to_b) bus_b.RxD = v;
      else      bus_a.RxD = v;
      repeat (len) @(negedge clk);
   endtask

   // abort_idx >= 0 drops Rx_EN in the middle of that data bit.
   task automatic send_a(input logic [7:0] d, input logic p, input logic s,
                         input int abort_idx);
      drive_bit(1'b0, 1'b0, BIT_A);
      for (int i = 0; i < 8; i++) begin
         if (i == abort_idx) begin
            bus_a.RxD = d[i];
            repeat (BIT_A / 2) @(negedge clk);
            bus_a.Rx_EN = 1'b0;
            repeat (BIT_A - BIT_A / 2) @(negedge clk);
         end else begin
            drive_bit(1'b0, d[i], BIT_A);
         end
      end
      drive_bit(1'b0, p, BIT_A);
      if (s) begin
         drive_bit(1'b0, 1'b1, BIT_A);
      end else begin
         drive_bit(1'b0, 1'b0, STOP_LOW_A);
         drive_bit(1'b0, 1'b1, BIT_A - STOP_LOW_A);
      end
   endtask

   task automatic send_b(input logic [7:0] d);
      drive_bit(1'b1, 1'b0, BIT_B);
      for (int i = 0; i < 8; i++) drive_bit(1'b1, d[i], BIT_B);
      drive_bit(1'b1, 1'b1, BIT_B);
   endtask

   initial begin
      vec_t       vecs [6];
      int         bv, bf, bp, bb;
      string      nm;
      logic [7:0] got;
      logic [7:0] exp_b [3];

      // data, parity bit, stop bit, expected Rx_DATA, VALID, FERROR, PERROR
      vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1};
      exp_b[0] = 8'h00;
      exp_b[1] = 8'hFF;
      exp_b[2] = 8'h55;

      reset             = 1'b0;
      bus_a.baud_select = 3'b111;
      bus_a.Rx_EN       = 1'b1;
      bus_a.RxD         = 1'b1;
      bus_b.baud_select = 3'b011;
      bus_b.Rx_EN       = 1'b1;
      bus_b.RxD         = 1'b1;

      // Reset held for 5 clk with the line toggling.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus_a.RxD = i[0];
         bus_b.RxD = ~i[0];
      end
      check("reset.data",  32'(bus_a.Rx_DATA),   32'h00);
      check("reset.valid", 32'(bus_a.Rx_VALID),  32'h0);
      check("reset.ferr",  32'(bus_a.Rx_FERROR), 32'h0);
      check("reset.perr",  32'(bus_a.Rx_PERROR), 32'h0);
      check("reset.b_data", 32'(bus_b.Rx_DATA),  32'h00);

      bus_a.RxD = 1'b1;
      bus_b.RxD = 1'b1;
      reset     = 1'b1;
      bv = n_val_a; bf = n_fe_a; bp = n_pe_a; bb = rx_b.size();
      repeat (1000) @(negedge clk);
      check("idle.pulses_a", 32'((n_val_a - bv) + (n_fe_a - bf) + (n_pe_a - bp)), 32'd0);
      check("idle.pulses_b", 32'((rx_b.size() - bb) + n_err_b), 32'd0);

      // Single frames from the table, one idle bit after each.
      for (int k = 0; k < 6; k++) begin
         bv = n_val_a; bf = n_fe_a; bp = n_pe_a;
         send_a(vecs[k].data, vecs[k].par, vecs[k].stop, -1);
         drive_bit(1'b0, 1'b1, BIT_A);
         $sformat(nm, "vec%0d", k);
         check({nm, ".valid"}, 32'(n_val_a - bv), 32'(vecs[k].exp_v));
         check({nm, ".ferr"},  32'(n_fe_a - bf),  32'(vecs[k].exp_fe));
         check({nm, ".perr"},  32'(n_pe_a - bp),  32'(vecs[k].exp_pe));
         check({nm, ".data"},  32'(bus_a.Rx_DATA), 32'(vecs[k].exp_data));
      end

      // Start glitch: line low for 4 sample ticks only.
      bv = n_val_a; bf = n_fe_a; bp = n_pe_a;
      bus_a.RxD = 1'b0;
      repeat (4 * 27) @(negedge clk);
      bus_a.RxD = 1'b1;
      repeat (1000) @(negedge clk);
      check("glitch.pulses", 32'((n_val_a - bv) + (n_fe_a - bf) + (n_pe_a - bp)), 32'd0);
      check("glitch.data",   32'(bus_a.Rx_DATA), 32'h80);

      // Rx_EN dropped during data bit 3.
      bv = n_val_a; bf = n_fe_a; bp = n_pe_a;
      send_a(8'h5A, 1'b0, 1'b1, 3);
      drive_bit(1'b0, 1'b1, BIT_A);
      bus_a.Rx_EN = 1'b1;
      repeat (BIT_A) @(negedge clk);
      check("abort.pulses", 32'((n_val_a - bv) + (n_fe_a - bf) + (n_pe_a - bp)), 32'd0);
      check("abort.data",   32'(bus_a.Rx_DATA), 32'h80);

      // Reset in the middle of a frame, then a clean frame.
      bv = n_val_a; bf = n_fe_a; bp = n_pe_a;
      drive_bit(1'b0, 1'b0, BIT_A);
      drive_bit(1'b0, 1'b0, BIT_A);
      drive_bit(1'b0, 1'b1, BIT_A);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("midreset.data", 32'(bus_a.Rx_DATA), 32'h00);
      bus_a.RxD = 1'b1;
      repeat (2 * BIT_A) @(negedge clk);
      reset = 1'b1;
      repeat (BIT_A) @(negedge clk);
      check("midreset.pulses", 32'((n_val_a - bv) + (n_fe_a - bf) + (n_pe_a - bp)), 32'd0);

      bv = n_val_a; bf = n_fe_a; bp = n_pe_a;
      send_a(8'h96, 1'b0, 1'b1, -1);
      drive_bit(1'b0, 1'b1, BIT_A);
      check("recover.valid", 32'(n_val_a - bv), 32'd1);
      check("recover.errs",  32'((n_fe_a - bf) + (n_pe_a - bp)), 32'd0);
      check("recover.data",  32'(bus_a.Rx_DATA), 32'h96);

      // Back-to-back frames at 9600 select, no parity, no idle gap.
      bb = rx_b.size();
      send_b(8'h00);
      send_b(8'hFF);
      send_b(8'h55);
      drive_bit(1'b1, 1'b1, BIT_B);
      check("b2b.count", 32'(rx_b.size() - bb), 32'd3);
      check("b2b.errs",  32'(n_err_b), 32'd0);
      for (int j = 0; j < 3; j++) begin
         got = ((bb + j) < rx_b.size()) ? rx_b[bb + j] : 8'hxx;
         $sformat(nm, "b2b.frame%0d", j);
         check(nm, 32'(got), 32'(exp_b[j]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Consumes the serial line and recovers 8-bit frames: 1 start bit, 8 data bits LSB first, optional even parity bit, 1 stop bit.
- Contains its own 16x-oversampling tick generator, driven by baud_select.
- Sits beside the transmit path in the Lab2 UART and feeds received bytes to the consumer logic.

Parameters:
- CLK_HZ, 50000000, system clock frequency. Used only for the divisor table in the package.
- OVERSAMPLE, 16, sample ticks per bit period. Fixed at 16; no other value is supported.
- PARITY_EN, 1, 1 = parity bit present and checked (even parity); 0 = no parity bit in the frame.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- baud_select  in  3  000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
- Rx_EN  in  1  receiver enable.
- RxD  in  1  asynchronous serial line; idles high.
- Rx_DATA  out  8  last received byte.
- Rx_VALID  out  1  one-cycle pulse: good frame received.
- Rx_FERROR  out  1  one-cycle pulse: stop bit sampled low.
- Rx_PERROR  out  1  one-cycle pulse: parity mismatch.

Behaviour:
- Reset (reset==0 at a clk edge): Rx_DATA=8'h00, Rx_VALID=0, Rx_FERROR=0, Rx_PERROR=0, FSM=IDLE, tick counter=0, synchronizer flops=1.
- Tick generator:
  - 16-bit counter, reloaded from DIVISOR[baud_select] (package table). Emits sample_tick for one clk cycle when the count reaches DIVISOR-1, then wraps to 0.
  - A change of baud_select restarts the count at 0.
  - The counter runs only while Rx_EN=1; otherwise it is held at 0.
- RxD path: 2-flop synchronizer to rxd_s. All line decisions use rxd_s only.
- FSM states: IDLE, START, DATA, PARITY, STOP. A 4-bit sub-tick counter sc counts sample_ticks within a bit.
  - IDLE: on rxd_s==0 with Rx_EN=1 -> START, sc=0.
  - START: at the sample_tick where sc==7 (mid-bit), rxd_s==1 is a glitch -> IDLE with no outputs. Otherwise at sc==15 -> DATA, bit index=0.
  - DATA: sample rxd_s at sc==7 into shift register bit[index], LSB first. At sc==15: after index 7 -> PARITY (PARITY_EN=1) or STOP (PARITY_EN=0); otherwise index+1.
  - PARITY: sample at sc==7. Perr = XOR(data bits, sampled parity bit). At sc==15 -> STOP.
  - STOP: sample at sc==7, then immediately -> IDLE. There is no wait for sc==15, so back-to-back frames resynchronize on the next falling edge.
- Outputs at the STOP sample cycle, registered, visible 1 cycle later:
  - Rx_DATA loads the shift register on every completed frame, including errored frames.
  - Stop bit low: Rx_FERROR=1.
  - Perr set: Rx_PERROR=1. Both flags may assert together.
  - Rx_VALID=1 only if neither error is set.
  - All pulses last exactly 1 clk cycle. Rx_DATA holds until the next completed frame.
- Rx_EN deasserted mid-frame: FSM -> IDLE on the next clk, with no pulses and Rx_DATA unchanged.
- Reset mid-frame: full reset as above, with no pulse emitted.
- Latency: Rx_VALID rises 1 clk after the stop-bit mid-sample tick, about 9.5 bit times after the start-bit falling edge (10.5 with parity).

Decomposition:
- Package uart_pkg:
  - baud divisor table DIVISOR[0..7] = CLK_HZ/(16*baud): 10417, 2604, 651, 326, 163, 81, 54, 27 at 50 MHz.
  - FSM state encoding.
  - DATA_BITS=8 constant.
- One sub-module, uart_sample_tick: divisor counter plus baud_select decode, producing sample_tick. It is reusable by the transmitter, which divides further by 16.

Test Plan:
- Reset: hold reset=0 for 5 clk while RxD toggles -> all outputs 0, Rx_DATA=8'h00. After release with RxD idle high -> no pulses for 1000 clk.
- Nominal frame: baud_select=3'b111, PARITY_EN=1, send 8'hA5 with parity 0 and stop bit 1 at 27*16 clk per bit -> Rx_VALID single pulse, Rx_DATA=8'hA5, no error pulses.
- Parity error: send 8'h01 with parity bit 0 -> Rx_PERROR pulse, Rx_VALID=0, Rx_DATA=8'h01.
- Framing error: send 8'h3C with stop bit 0 -> Rx_FERROR pulse, Rx_VALID=0. A following frame 8'hC3 with correct stop bit is received with Rx_VALID.
- Glitch and abort: RxD low for 4 ticks, then high -> no pulse, FSM back in IDLE. Drop Rx_EN during data bit 3 of a frame -> no pulse, Rx_DATA unchanged.
- Baud sweep and back-to-back: baud_select=3'b011 (9600), three frames 8'h00, 8'hFF, 8'h55 with no idle gap -> three Rx_VALID pulses with the matching data in order.
